// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
//   Bus between N requesters and the shared register arbiter.
//   req/wdata/clr : requester side -> arbiter
//   gnt           : one-hot write strobe, one cycle per write
//   q/q_n         : shared register value and its registered complement
//   last_id       : index of the most recent winner
//   busy          : arbiter is writing or inside its quiet gap
interface shared_reg_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic               clr;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_n;
    logic [IW-1:0]      last_id;
    logic               busy;

    modport master (
        output req, wdata, clr,
        input  gnt, q, q_n, last_id, busy
    );

    modport slave (
        input  req, wdata, clr,
        output gnt, q, q_n, last_id, busy
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter sharing one WIDTH-bit register between N requesters.
//   One winner per arbitration is written into q (q_n registered as ~q);
//   after each write the arbiter stays quiet for HOLD cycles.
//   Ports:
//     clk  : clock, all state changes on posedge
//     rst  : synchronous active-high reset
//     bus  : shared_reg_arbiter_if.slave (req, wdata, clr in; gnt, q, q_n,
//            last_id, busy out)

// Per-requester front end: masks a request that is being granted this
// cycle, and flags requests at or above the round-robin pointer.
module shared_reg_arbiter_lane #(
    parameter int IDX = 0,
    parameter int PW  = 2
) (
    input  logic          req,
    input  logic          gnt,
    input  logic [PW-1:0] ptr,
    output logic          ereq,
    output logic          ereq_hi
);
    localparam logic [PW-1:0] ID = PW'(IDX);

    assign ereq    = req & ~gnt;
    assign ereq_hi = ereq & (ID >= ptr);
endmodule

module shared_reg_arbiter #(
    parameter int               N       = 4,
    parameter int               WIDTH   = 8,
    parameter int               HOLD    = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_reg_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_M1 = (HOLD > 0) ? CW'(HOLD - 1) : '0;
    localparam logic [PW-1:0] LAST   = PW'(N - 1);

    typedef enum logic {IDLE, GAP} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [N-1:0]              gnt_q, gnt_d;
    logic [WIDTH-1:0]          q_q, q_d, qn_q;
    logic [PW-1:0]             last_q, last_d;

    logic [N-1:0][WIDTH-1:0]   wd;
    logic [N-1:0]              ereq, ereq_hi, pick;
    logic [PW-1:0]             win;

    assign wd = bus.wdata;

    for (genvar i = 0; i < N; i++) begin : g_lane
        shared_reg_arbiter_lane #(.IDX(i), .PW(PW)) u_lane (
            .req     (bus.req[i]),
            .gnt     (gnt_q[i]),
            .ptr     (ptr_q),
            .ereq    (ereq[i]),
            .ereq_hi (ereq_hi[i])
        );
    end

    // Round-robin pick: lowest request at/after ptr, else wrap to the lowest
    // request overall.
    always_comb begin
        pick = (|ereq_hi) ? ereq_hi : ereq;
        win  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) win = PW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        q_d     = q_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (!bus.clr && (|ereq)) begin
                    q_d        = wd[win];
                    gnt_d[win] = 1'b1;
                    last_d     = win;
                    ptr_d      = (win == LAST) ? '0 : win + 1'b1;
                    if (HOLD > 0) begin
                        state_d = GAP;
                        cnt_d   = HOLD_M1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Clear wins over any write on the same edge; the write path above
        // is already gated so no gnt is issued.
        if (bus.clr) q_d = RST_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= RST_VAL;
            qn_q    <= ~RST_VAL;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            qn_q    <= ~q_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_n     = qn_q;
    assign bus.last_id = last_q;
    assign bus.busy    = (state_q != IDLE) | (|gnt_q);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed bench for shared_reg_arbiter (N=4, WIDTH=8, HOLD=2, RST_VAL=0).
//   Expected writes are queued when a request is driven and compared when
//   the arbiter issues a grant.
module tb_shared_reg_arbiter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_cyc = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];

    shared_reg_arbiter_if #(.N(4), .WIDTH(8)) bus ();

    shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD(2), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wd(input int i, input logic [7:0] v);
        bus.wdata[i*8 +: 8] = v;
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] v, input logic [1:0] id);
        exp_t e;
        e.gnt = g;
        e.q   = v;
        e.id  = id;
        sb.push_back(e);
    endtask

    // Wait up to budget edges for a grant, then compare it with the head of
    // the scoreboard. spacing>0 also checks edges since the previous grant.
    task automatic wait_grant(input string tag, input int budget, input int spacing, input bit drop);
        exp_t       e;
        logic [7:0] qn_exp;
        bit         got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (bus.gnt != 4'b0) begin
                got = 1;
                chk({tag, "_sb"}, 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e      = sb.pop_front();
                    qn_exp = ~e.q;
                    chk({tag, "_gnt"}, bus.gnt, e.gnt);
                    chk({tag, "_q"}, bus.q, e.q);
                    chk({tag, "_qn"}, bus.q_n, qn_exp);
                    chk({tag, "_id"}, bus.last_id, e.id);
                end
                if (spacing > 0) chk({tag, "_spacing"}, cyc - last_cyc, spacing);
                last_cyc = cyc;
                if (drop) bus.req = bus.req & ~bus.gnt;
            end
        end
        chk({tag, "_seen"}, 32'(got), 1);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        bus.clr   = 1'b0;
        bus.wdata = '0;
        bus.req   = 4'b1111;
        set_wd(0, 8'h11); set_wd(1, 8'h22); set_wd(2, 8'h33); set_wd(3, 8'h44);

        // reset holds everything quiet even with all requests up
        repeat (2) begin
            step();
            chk("rst_q", bus.q, 8'h00);
            chk("rst_qn", bus.q_n, 8'hFF);
            chk("rst_gnt", bus.gnt, 4'b0);
            chk("rst_busy", bus.busy, 1'b0);
        end
        chk("rst_id", bus.last_id, 2'd0);
        rst     = 1'b0;
        bus.req = 4'b0;
        step();

        // single write, one-cycle latency and one-cycle gnt pulse
        set_wd(2, 8'hA5);
        bus.req = 4'b0100;
        push(4'b0100, 8'hA5, 2'd2);
        wait_grant("single", 1, 0, 1);
        chk("single_busy", bus.busy, 1'b1);
        step();
        chk("single_pulse", bus.gnt, 4'b0);
        chk("single_keep_q", bus.q, 8'hA5);
        chk("single_gap_busy", bus.busy, 1'b1);
        repeat (3) step();
        chk("single_idle_busy", bus.busy, 1'b0);

        // round robin from ptr=0 with all requests held
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_wd(0, 8'h10); set_wd(1, 8'h21); set_wd(2, 8'h32); set_wd(3, 8'h43);
        bus.req = 4'b1111;
        push(4'b0001, 8'h10, 2'd0);
        push(4'b0010, 8'h21, 2'd1);
        push(4'b0100, 8'h32, 2'd2);
        push(4'b1000, 8'h43, 2'd3);
        push(4'b0001, 8'h10, 2'd0);
        wait_grant("rr0", 1, 0, 0);
        wait_grant("rr1", 4, 3, 0);
        wait_grant("rr2", 4, 3, 0);
        wait_grant("rr3", 4, 3, 0);
        wait_grant("rr4", 4, 3, 0);
        bus.req = 4'b0;
        repeat (3) step();

        // clear beats a simultaneous write; request stays pending
        set_wd(0, 8'h3C);
        bus.req = 4'b0001;
        bus.clr = 1'b1;
        step();
        chk("clr_q", bus.q, 8'h00);
        chk("clr_qn", bus.q_n, 8'hFF);
        chk("clr_gnt", bus.gnt, 4'b0);
        bus.clr = 1'b0;
        push(4'b0001, 8'h3C, 2'd0);
        wait_grant("clr_wr", 1, 0, 1);

        // pointer wrap: 3 -> 0, then 0 -> 3 with req=1001
        set_wd(3, 8'hD3);
        bus.req = 4'b1000;
        push(4'b1000, 8'hD3, 2'd3);
        wait_grant("to3", 4, 3, 1);
        set_wd(0, 8'hE0);
        bus.req = 4'b1001;
        push(4'b0001, 8'hE0, 2'd0);
        wait_grant("wrap0", 4, 3, 1);
        bus.req = 4'b1001;
        push(4'b1000, 8'hD3, 2'd3);
        wait_grant("wrap3", 4, 3, 1);
        bus.req = 4'b0;
        repeat (3) step();

        // reset in the gap: pending request wins one edge after rst drops
        set_wd(1, 8'h77);
        bus.req = 4'b0010;
        push(4'b0010, 8'h77, 2'd1);
        wait_grant("pre_rst", 1, 0, 1);
        rst = 1'b1;
        set_wd(2, 8'h99);
        bus.req = 4'b0100;
        step();
        chk("gaprst_q", bus.q, 8'h00);
        chk("gaprst_gnt", bus.gnt, 4'b0);
        chk("gaprst_busy", bus.busy, 1'b0);
        chk("gaprst_id", bus.last_id, 2'd0);
        rst = 1'b0;
        push(4'b0100, 8'h99, 2'd2);
        wait_grant("post_rst", 1, 0, 1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
